cam_decoder_sched: RTL and testbench
====================================

Name: cam_decoder_sched

Overview:
- Parametrised successor to the combinational CAM decoder.
- Accepts read, write, search and invalidate requests, each through its own one-deep request slot with a ready signal.
- The CAM array is single-ported, so the block issues at most one operation per cycle.
- Outputs are registered one-hot (read/write) or valid-masked (search) enable vectors, plus a per-entry valid bitmap.
- Sits between the CAM controller front end and the CAM storage array.

Parameters:
- DATA_WIDTH, 32, CAM entry width; passed through, not used in decode logic.
- ADDR_WIDTH, 5, index width.
- DEPTH, 1<<ADDR_WIDTH, number of entries.
- STARVE_LIMIT, 4, cycles a pending op waits before it gains top priority (1..15).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- read_i  in  1  read request.
- read_index_i  in  ADDR_WIDTH  read entry index.
- read_ready_o  out  1  read slot empty.
- write_i  in  1  write request.
- write_index_i  in  ADDR_WIDTH  write entry index.
- write_ready_o  out  1  write slot empty.
- search_i  in  1  search request.
- search_ready_o  out  1  search slot empty.
- inval_i  in  1  invalidate request.
- inval_index_i  in  ADDR_WIDTH  entry index to invalidate.
- read_enable_o  out  DEPTH  one-hot read word line.
- write_enable_o  out  DEPTH  one-hot write word line.
- search_enable_o  out  DEPTH  match-line enables, equal to valid bitmap at issue.
- valid_o  out  DEPTH  per-entry valid bitmap.
- issue_valid_o  out  1  an enable vector is active this cycle.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous and active-high.
- Reset values: all enable outputs, valid_o and issue_valid_o are 0; slots and age counters are empty/0; all *_ready_o are 1.
- Accept rule: a request is accepted when req && ready at a rising edge. The index is captured into the slot and ready drops the next cycle. A request with ready=0 is ignored, not queued.
- Invalidate: takes effect on the cycle it is asserted. It clears valid_o[inval_index_i] at the next edge, needs no slot and is not arbitrated. If the same edge also issues a write to the same index, the write wins and the bit ends at 1.
- Issue stage: each cycle, at most one full slot is selected.
  - Default priority: write > search > read.
  - Each full, non-selected slot increments a 4-bit saturating age counter.
  - A slot whose age is >= STARVE_LIMIT overrides the default priority.
  - If several slots have aged, the default order breaks the tie.
  - The selected slot empties and its age clears. Its ready is 1 on the following cycle, so back-to-back acceptance on one channel gives at most one op per 2 cycles.
- Outputs: registered, latency 1 cycle from issue selection. Only one of the three vectors is nonzero in any cycle, and issue_valid_o matches that.
- write_enable_o: one-hot at the index. The issue edge also sets valid_o[index] (valid_o updates in the same cycle write_enable_o appears).
- read_enable_o: one-hot at the index, regardless of valid.
- search_enable_o: equals valid_o as it stands at the issue edge, before that edge's write/invalidate update. If valid_o is all zero, search_enable_o is 0 but issue_valid_o is still 1.
- Throughput: request accepted at edge N gives an output at edge N+2 at the earliest (slot at N, issue select at N+1, register at N+2).
- Index range: indexes >= DEPTH, possible only when DEPTH < 2^ADDR_WIDTH, give an all-zero enable. The op still issues, issue_valid_o=1, and valid_o is unchanged.
- Reset mid-operation: reset_i overrides everything. Pending slots are discarded and outputs are 0 at the next edge.

Optional Feature:
- Macro CAM_DECODER_SCHED_STATS_EN.
- When defined: adds 16-bit wrapping output counters read_cnt_o, write_cnt_o, search_cnt_o (issued ops) and starve_cnt_o (issues won through the age override). All reset to 0.
- When undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Write idx 3, then read idx 3 → write_enable_o=0x00000008, valid_o=0x8, then read_enable_o=0x8; issue_valid_o pulses once for each op.
- Write, search and read all asserted on the same edge (indexes 1, –, 2) → issue order write (0x2), search (search_enable_o=0x2), read (0x4) on consecutive cycles.
- STARVE_LIMIT=4: read pending while a write to idx 0 is requested every time write_ready_o is high → the read issues no later than 4 cycles after it was accepted; with STATS, starve_cnt_o increments.
- Write idx 5 plus same-edge inval idx 5 → valid_o[5]=1. Inval idx 5 alone → valid_o[5]=0. A following search → search_enable_o lacks bit 5.
- Search with an empty CAM after reset → search_enable_o=0, issue_valid_o=1.
- Assert reset_i while all slots are full → the next cycle has all enables 0, valid_o=0, all readies 1, and no stale issue afterwards.

Source files
------------

// File: rtl/cam_decoder_sched.sv
// cam_decoder_sched: arbitrated CAM decoder issuing one registered read/write/search enable per cycle.
// Optional CAM_DECODER_SCHED_STATS_EN adds issue and starvation counters.
module cam_decoder_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 1 << ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  read_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  output logic                  read_ready_o,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  output logic                  write_ready_o,
  input  logic                  search_i,
  output logic                  search_ready_o,
  input  logic                  inval_i,
  input  logic [ADDR_WIDTH-1:0] inval_index_i,
  output logic [DEPTH-1:0]      read_enable_o,
  output logic [DEPTH-1:0]      write_enable_o,
  output logic [DEPTH-1:0]      search_enable_o,
  output logic [DEPTH-1:0]      valid_o,
  output logic                  issue_valid_o
`ifdef CAM_DECODER_SCHED_STATS_EN
  ,
  output logic [15:0]           read_cnt_o,
  output logic [15:0]           write_cnt_o,
  output logic [15:0]           search_cnt_o,
  output logic [15:0]           starve_cnt_o
`endif
);
  typedef enum logic [1:0] {OP_WR, OP_SR, OP_RD} op_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};
  if (DATA_WIDTH < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
    $error("cam_decoder_sched: bad parameter");
  end
  function automatic logic [DEPTH-1:0] hot(input logic [ADDR_WIDTH-1:0] i);
    hot = (32'(i) < DEPTH) ? ONE << i : '0;
  endfunction
  logic wr_full, sr_full, rd_full;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx, iss_idx;
  logic [3:0] wr_age, sr_age, rd_age;
  logic iss_v;
  op_t iss_op;
  logic wr_old, sr_old, rd_old, any_old, sel_wr, sel_sr, sel_rd, sel_any;
  logic [DEPTH-1:0] iss_hot, inv_hot;
  assign write_ready_o  = !wr_full;
  assign search_ready_o = !sr_full;
  assign read_ready_o   = !rd_full;
  // aged slots pre-empt the default write > search > read order
  always_comb begin
    wr_old  = wr_full && wr_age >= LIM;
    sr_old  = sr_full && sr_age >= LIM;
    rd_old  = rd_full && rd_age >= LIM;
    any_old = wr_old || sr_old || rd_old;
    sel_wr  = any_old ? wr_old : wr_full;
    sel_sr  = (any_old ? sr_old : sr_full) && !sel_wr;
    sel_rd  = (any_old ? rd_old : rd_full) && !sel_wr && !sel_sr;
    sel_any = sel_wr || sel_sr || sel_rd;
    iss_hot = hot(iss_idx);
    inv_hot = inval_i ? hot(inval_index_i) : '0;
  end
`ifdef CAM_DECODER_SCHED_STATS_EN
  logic iss_starve;
  logic starve_win;
  assign starve_win = (sel_wr != wr_full) || (sel_sr != (sr_full && !wr_full));
`endif
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_full <= 1'b0;
      sr_full <= 1'b0;
      rd_full <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
      wr_age <= '0;
      sr_age <= '0;
      rd_age <= '0;
      iss_v <= 1'b0;
      iss_op <= OP_WR;
      iss_idx <= '0;
      read_enable_o <= '0;
      write_enable_o <= '0;
      search_enable_o <= '0;
      valid_o <= '0;
      issue_valid_o <= 1'b0;
`ifdef CAM_DECODER_SCHED_STATS_EN
      iss_starve <= 1'b0;
      read_cnt_o <= '0;
      write_cnt_o <= '0;
      search_cnt_o <= '0;
      starve_cnt_o <= '0;
`endif
    end else begin
      wr_full <= sel_wr ? 1'b0 : wr_full | write_i;
      sr_full <= sel_sr ? 1'b0 : sr_full | search_i;
      rd_full <= sel_rd ? 1'b0 : rd_full | read_i;
      if (write_i && !wr_full) wr_idx <= write_index_i;
      if (read_i && !rd_full) rd_idx <= read_index_i;
      wr_age <= (wr_full && !sel_wr) ? wr_age + {3'b0, wr_age != 4'hf} : 4'h0;
      sr_age <= (sr_full && !sel_sr) ? sr_age + {3'b0, sr_age != 4'hf} : 4'h0;
      rd_age <= (rd_full && !sel_rd) ? rd_age + {3'b0, rd_age != 4'hf} : 4'h0;
      iss_v <= sel_any;
      iss_op <= sel_wr ? OP_WR : sel_sr ? OP_SR : OP_RD;
      iss_idx <= sel_wr ? wr_idx : rd_idx;
      issue_valid_o <= iss_v;
      write_enable_o <= (iss_v && iss_op == OP_WR) ? iss_hot : '0;
      read_enable_o <= (iss_v && iss_op == OP_RD) ? iss_hot : '0;
      search_enable_o <= (iss_v && iss_op == OP_SR) ? valid_o : '0;
      valid_o <= (valid_o & ~inv_hot) | ((iss_v && iss_op == OP_WR) ? iss_hot : '0);
`ifdef CAM_DECODER_SCHED_STATS_EN
      iss_starve <= sel_any && starve_win;
      if (iss_v && iss_op == OP_RD) read_cnt_o <= read_cnt_o + 16'd1;
      if (iss_v && iss_op == OP_WR) write_cnt_o <= write_cnt_o + 16'd1;
      if (iss_v && iss_op == OP_SR) search_cnt_o <= search_cnt_o + 16'd1;
      if (iss_v && iss_starve) starve_cnt_o <= starve_cnt_o + 16'd1;
`endif
    end
  end
endmodule

// File: tb/tb_cam_decoder_sched.sv
// tb_cam_decoder_sched: scoreboard bench for cam_decoder_sched with an array-based reference model.
module tb_cam_decoder_sched;
  localparam int D = 24;
  localparam int AW = 5;
  localparam int LIM = 4;
  typedef struct {
    int cyc;
    logic [D-1:0] we, se, re, v;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  bit r_rst = 1'b1;
  bit r_req[3];
  int r_idx[3];
  bit r_inv;
  int r_iidx;
  logic read_ready_o, write_ready_o, search_ready_o, issue_valid_o;
  logic [D-1:0] read_enable_o, write_enable_o, search_enable_o, valid_o;
  cam_decoder_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(D), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .reset_i(r_rst),
    .read_i(r_req[2]), .read_index_i(AW'(r_idx[2])), .read_ready_o(read_ready_o),
    .write_i(r_req[0]), .write_index_i(AW'(r_idx[0])), .write_ready_o(write_ready_o),
    .search_i(r_req[1]), .search_ready_o(search_ready_o),
    .inval_i(r_inv), .inval_index_i(AW'(r_iidx)),
    .read_enable_o(read_enable_o), .write_enable_o(write_enable_o),
    .search_enable_o(search_enable_o), .valid_o(valid_o), .issue_valid_o(issue_valid_o)
  );
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit started = 1'b0;
  exp_t q[$];
  int m_full[3], m_idx[3], m_age[3];
  bit p_v;
  int p_op, p_idx;
  logic [D-1:0] mv;
  function automatic logic [D-1:0] hot(input int i);
    logic [D-1:0] one = {{(D-1){1'b0}}, 1'b1};
    return (i < D) ? one << i : '0;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // reference: what happens at one rising edge given the current request wires
  task automatic model_edge();
    logic [D-1:0] nv;
    bit acc;
    int win;
    if (r_rst) begin
      for (int c = 0; c < 3; c++) begin
        m_full[c] = 0;
        m_age[c] = 0;
      end
      p_v = 0;
      mv = '0;
      return;
    end
    nv = mv;
    if (r_inv && r_iidx < D) nv[r_iidx] = 1'b0;
    if (p_v) begin
      exp_t e;
      e.cyc = cyc + 1;
      e.we = (p_op == 0) ? hot(p_idx) : '0;
      e.se = (p_op == 1) ? mv : '0;
      e.re = (p_op == 2) ? hot(p_idx) : '0;
      if (p_op == 0 && p_idx < D) nv[p_idx] = 1'b1;
      e.v = nv;
      q.push_back(e);
    end
    mv = nv;
    win = -1;
    for (int c = 0; c < 3; c++) if (m_full[c] != 0 && m_age[c] >= LIM && win < 0) win = c;
    for (int c = 0; c < 3; c++) if (m_full[c] != 0 && win < 0) win = c;
    p_v = (win >= 0);
    if (p_v) begin
      p_op = win;
      p_idx = m_idx[win];
    end
    for (int c = 0; c < 3; c++) begin
      acc = r_req[c] && m_full[c] == 0;
      if (c == win) begin
        m_full[c] = 0;
        m_age[c] = 0;
      end else if (m_full[c] != 0) m_age[c] = (m_age[c] == 15) ? 15 : m_age[c] + 1;
      if (acc) begin
        m_full[c] = 1;
        m_idx[c] = r_idx[c];
      end
    end
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("write_ready", 64'(write_ready_o), 64'(m_full[0] == 0));
    chk("search_ready", 64'(search_ready_o), 64'(m_full[1] == 0));
    chk("read_ready", 64'(read_ready_o), 64'(m_full[2] == 0));
    chk("valid", 64'(valid_o), 64'(mv));
    r_rst = 0;
    r_inv = 0;
    for (int c = 0; c < 3; c++) r_req[c] = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  always @(negedge clk) begin
    if (started) begin
      if (issue_valid_o === 1'b1) begin
        if (q.size() == 0) chk("unexpected_issue", 64'(1), 64'(0));
        else begin
          exp_t e;
          e = q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("write_enable", 64'(write_enable_o), 64'(e.we));
          chk("search_enable", 64'(search_enable_o), 64'(e.se));
          chk("read_enable", 64'(read_enable_o), 64'(e.re));
          chk("issue_valid", 64'(valid_o), 64'(e.v));
        end
      end else begin
        chk("idle_enables", 64'(read_enable_o | write_enable_o | search_enable_o), 64'(0));
        chk("issue_valid_known", 64'(issue_valid_o), 64'(0));
      end
    end
  end
  initial begin
    for (int c = 0; c < 3; c++) begin
      r_req[c] = 0;
      r_idx[c] = 0;
    end
    r_inv = 0;
    r_iidx = 0;
    r_rst = 1;
    tick();
    started = 1;
    r_rst = 1;
    tick();
    // empty CAM search
    r_req[1] = 1;
    idle(3);
    chk("empty_search_iv", 64'(issue_valid_o), 64'(1));
    chk("empty_search_se", 64'(search_enable_o), 64'(0));
    // write 3 then read 3
    r_req[0] = 1;
    r_idx[0] = 3;
    idle(3);
    chk("wr3_enable", 64'(write_enable_o), 64'h8);
    chk("wr3_valid", 64'(valid_o), 64'h8);
    r_req[2] = 1;
    r_idx[2] = 3;
    idle(3);
    chk("rd3_enable", 64'(read_enable_o), 64'h8);
    idle(2);
    // simultaneous write/search/read
    r_req[0] = 1; r_idx[0] = 1;
    r_req[1] = 1;
    r_req[2] = 1; r_idx[2] = 2;
    idle(3);
    chk("tri_write", 64'(write_enable_o), 64'h2);
    idle(1);
    chk("tri_search", 64'(search_enable_o), 64'ha);
    idle(1);
    chk("tri_read", 64'(read_enable_o), 64'h4);
    idle(2);
    // write 5 with same-edge inval 5, then inval alone, then search
    r_req[0] = 1; r_idx[0] = 5;
    r_inv = 1; r_iidx = 5;
    idle(4);
    chk("wr5_inval_keep", 64'(valid_o[5]), 64'(1));
    r_inv = 1; r_iidx = 5;
    idle(1);
    chk("inval5", 64'(valid_o[5]), 64'(0));
    r_req[1] = 1;
    idle(4);
    // sustained contention on all channels drives the age override
    for (int i = 0; i < 40; i++) begin
      r_req[0] = 1; r_idx[0] = 0;
      r_req[1] = 1;
      r_req[2] = 1; r_idx[2] = i % 32;
      tick();
    end
    // reset with every slot full
    r_req[0] = 1; r_req[1] = 1; r_req[2] = 1;
    tick();
    r_rst = 1;
    tick();
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_ready", 64'({write_ready_o, search_ready_o, read_ready_o}), 64'h7);
    idle(4);
    // randomized traffic including out-of-range indexes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++) begin
        r_req[c] = ($urandom_range(0, 2) != 0);
        r_idx[c] = $urandom_range(0, 31);
      end
      r_inv = ($urandom_range(0, 3) == 0);
      r_iidx = $urandom_range(0, 31);
      r_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle(6);
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
